bus_req_arbiter: RTL and testbench



---
 rtl/cache_types.sv | 41 ++++
 rtl/bus_req_arbiter_rr_picker.sv | 29 ++
 rtl/bus_req_arbiter.sv | 142 ++++++++++++++
 tb/tb_bus_req_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types.sv
// Shared coherence message types for the L1 caches, snoop bus and memory controller.
// Also carries arbiter sizing and small helpers used by the snoop bus request arbiter.
package cache_types;

  localparam int NUM_CACHE = 8;
  localparam int MSG_SRC_W = $clog2(NUM_CACHE) + 1;
  localparam int ARB_PTR_W = $clog2(NUM_CACHE);
  localparam int ADDR_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GETS = 2'd1,
    GETM = 2'd2,
    PUTM = 2'd3
  } bus_tx_t;

  typedef struct packed {
    logic                 valid;
    logic [MSG_SRC_W-1:0] source;
    logic [ADDR_W-1:0]    addr;
    bus_tx_t              bus_tx;
  } req_msg_t;

  typedef struct packed {
    logic                 valid;
    logic [MSG_SRC_W-1:0] source;
    logic [MSG_SRC_W-1:0] destination;
    logic [ADDR_W-1:0]    addr;
    logic                 memory_flag;
  } resp_msg_t;

  // GETS/GETM expect a data response; PUTM completes on the bus.
  function automatic logic is_data_tx(input bus_tx_t tx);
    return (tx == GETS) || (tx == GETM);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bus_req_arbiter_rr_picker.sv
// Round-robin first-eligible search starting at ptr, wrapping at N.
// Purely combinational, zero latency; no backpressure of its own.
module rr_picker #(
  parameter int N     = 8,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic             grant_valid,
  output logic [PTR_W-1:0] grant_idx
);

  logic [PTR_W:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(N)) idx = idx - (PTR_W+1)'(N);
      if (!grant_valid && eligible[idx[PTR_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_req_arbiter.sv
// Snoop bus request arbiter: one slot per L1, round-robin grant, one-cycle broadcast.
// Latency: accept at edge N, bus_req.valid after edge N+1. Backpressure: req_ready = slot empty; bus_stall blocks grants.
// Optional BUS_ARB_PERF_EN macro enables saturating grant/stall performance counters.
module bus_req_arbiter
  import cache_types::*;
#(
  parameter int NUM_REQ = NUM_CACHE,
  parameter int SRC_W   = $clog2(NUM_CACHE) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  req_msg_t [NUM_REQ-1:0]     req_in,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       bus_stall,
  input  resp_msg_t                  resp_in,
  output req_msg_t                   bus_req,
  output logic [SRC_W-1:0]           grant_id,
  output logic [31:0]                perf_gets,
  output logic [31:0]                perf_getm,
  output logic [31:0]                perf_putm,
  output logic [31:0]                perf_stall
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] slot_full;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_oh;
  logic [ADDR_W-1:0]  slot_addr [NUM_REQ];
  bus_tx_t            slot_tx   [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               do_grant;
  logic               retire_vld;

  assign req_ready  = ~slot_full;
  assign do_grant   = pick_vld & ~bus_stall;
  assign retire_vld = resp_in.valid & ~resp_in.memory_flag;
  assign grant_oh   = do_grant ? (NUM_REQ'(1) << pick_idx) : '0;

  // A PUTM may go out while the same cache still waits on data; loads/stores may not.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = slot_full[i] & ~(pending[i] & (slot_tx[i] != PUTM));
    end
  end

  rr_picker #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr),
    .grant_valid (pick_vld),
    .grant_idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_full <= '0;
      pending   <= '0;
      rr_ptr    <= '0;
      bus_req   <= '0;
      grant_id  <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_addr[i] <= '0;
        slot_tx[i]   <= IDLE;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_oh[i]) begin
          slot_full[i] <= 1'b0;
        end else if (req_valid[i] && !slot_full[i] && (req_in[i].bus_tx != IDLE)) begin
          slot_full[i] <= 1'b1;
          slot_addr[i] <= req_in[i].addr;
          slot_tx[i]   <= req_in[i].bus_tx;
        end
      end

      // Set after clear so a fresh grant outranks a retire for the same cache.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (retire_vld && (resp_in.destination == MSG_SRC_W'(i))) pending[i] <= 1'b0;
        if (grant_oh[i] && is_data_tx(slot_tx[i])) pending[i] <= 1'b1;
      end

      bus_req <= '0;
      if (do_grant) begin
        bus_req.valid  <= 1'b1;
        bus_req.source <= MSG_SRC_W'(pick_idx);
        bus_req.addr   <= slot_addr[pick_idx];
        bus_req.bus_tx <= slot_tx[pick_idx];
        grant_id       <= SRC_W'(pick_idx);
        rr_ptr         <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
      end
    end
  end

`ifdef BUS_ARB_PERF_EN
  logic [31:0] gets_q;
  logic [31:0] getm_q;
  logic [31:0] putm_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      gets_q  <= '0;
      getm_q  <= '0;
      putm_q  <= '0;
      stall_q <= '0;
    end else begin
      if (do_grant && slot_tx[pick_idx] == GETS) gets_q <= sat_inc32(gets_q);
      if (do_grant && slot_tx[pick_idx] == GETM) getm_q <= sat_inc32(getm_q);
      if (do_grant && slot_tx[pick_idx] == PUTM) putm_q <= sat_inc32(putm_q);
      if (bus_stall && |slot_full)               stall_q <= sat_inc32(stall_q);
    end
  end

  assign perf_gets  = gets_q;
  assign perf_getm  = getm_q;
  assign perf_putm  = putm_q;
  assign perf_stall = stall_q;
`else
  assign perf_gets  = '0;
  assign perf_getm  = '0;
  assign perf_putm  = '0;
  assign perf_stall = '0;
`endif

  // Message fields the arbiter never consumes.
  logic unused_msg_bits;
  always_comb begin
    unused_msg_bits = ^{resp_in.source, resp_in.addr};
    for (int i = 0; i < NUM_REQ; i++) begin
      unused_msg_bits = unused_msg_bits ^ req_in[i].valid ^ (^req_in[i].source);
    end
  end

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Scoreboard bench for bus_req_arbiter: expected grants queued at stimulus, compared at broadcast.
// Perf counter expectations follow whether BUS_ARB_PERF_EN is defined for the build.
module tb_bus_req_arbiter;
  import cache_types::*;

  localparam int N = NUM_CACHE;

  typedef struct {
    int          src;
    logic [31:0] addr;
    bus_tx_t     tx;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid;
  req_msg_t [N-1:0]     req_in;
  logic [N-1:0]         req_ready;
  logic                 bus_stall;
  resp_msg_t            resp_in;
  req_msg_t             bus_req;
  logic [MSG_SRC_W-1:0] grant_id;
  logic [31:0]          perf_gets, perf_getm, perf_putm, perf_stall;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  always #5 clk = ~clk;

  bus_req_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_in     (req_in),
    .req_ready  (req_ready),
    .bus_stall  (bus_stall),
    .resp_in    (resp_in),
    .bus_req    (bus_req),
    .grant_id   (grant_id),
    .perf_gets  (perf_gets),
    .perf_getm  (perf_getm),
    .perf_putm  (perf_putm),
    .perf_stall (perf_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input bus_tx_t tx, input logic [31:0] addr);
    req_valid[i]        = 1'b1;
    req_in[i]           = '0;
    req_in[i].valid     = 1'b1;
    req_in[i].source    = MSG_SRC_W'(7 - i);
    req_in[i].addr      = addr;
    req_in[i].bus_tx    = tx;
  endtask

  task automatic expect_grant(input int src, input bus_tx_t tx, input logic [31:0] addr);
    exp_t e;
    e.src = src; e.addr = addr; e.tx = tx;
    exp_q.push_back(e);
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_in    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic respond(input int dest, input logic mem_flag);
    resp_in             = '0;
    resp_in.valid       = 1'b1;
    resp_in.destination = MSG_SRC_W'(dest);
    resp_in.memory_flag = mem_flag;
    resp_in.addr        = 32'hDEAD_0000;
  endtask

  task automatic check_perf(input string tag, input logic [31:0] obs, input logic [31:0] en_val);
`ifdef BUS_ARB_PERF_EN
    check(tag, 64'(obs), 64'(en_val));
`else
    check(tag, 64'(obs), 64'(en_val & 32'h0));
`endif
  endtask

  // Broadcast monitor: every valid cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus_req.valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 64'(bus_req.source), 64'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("grant_src",  64'(bus_req.source), 64'(e.src));
        check("grant_id",   64'(grant_id),       64'(e.src));
        check("grant_addr", 64'(bus_req.addr),   64'(e.addr));
        check("grant_tx",   64'(bus_req.bus_tx), 64'(e.tx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus_stall = 1'b0;
    resp_in   = '0;
    clear_reqs();
    do_reset();

    // Reset state
    check("rst_bus_req",   64'(bus_req),   64'h0);
    check("rst_grant_id",  64'(grant_id),  64'h0);
    check("rst_req_ready", 64'(req_ready), 64'hFF);
    check("rst_perf_gets", 64'(perf_gets), 64'h0);
    check("rst_perf_stall",64'(perf_stall),64'h0);

    // Single GETS from requester 3
    send(3, GETS, 32'h1000);
    expect_grant(3, GETS, 32'h1000);
    tick();
    clear_reqs();
    check("gets_ready_low",  64'(req_ready[3]),  64'h0);
    check("gets_not_yet",    64'(bus_req.valid), 64'h0);
    tick();
    check("gets_ready_high", 64'(req_ready[3]),  64'h1);
    check("gets_valid",      64'(bus_req.valid), 64'h1);
    tick();
    check("gets_one_cycle",  64'(bus_req.valid), 64'h0);

    // All 8 PUTM at once: grants 0..7, then wrap
    do_reset();
    for (int i = 0; i < N; i++) begin
      send(i, PUTM, 32'h2000 + 32'(i * 64));
      expect_grant(i, PUTM, 32'h2000 + 32'(i * 64));
    end
    tick();
    clear_reqs();
    for (int k = 0; k < N; k++) begin
      tick();
      check("rr_order", 64'(grant_id), 64'(k));
    end
    send(1, PUTM, 32'h2F40);
    send(0, PUTM, 32'h2F00);
    expect_grant(0, PUTM, 32'h2F00);
    expect_grant(1, PUTM, 32'h2F40);
    tick();
    clear_reqs();
    tick();
    tick();
    tick();
    check_perf("perf_putm_10", perf_putm, 32'd10);

    // GETM then GETS from requester 2: held until a cache-side retire
    do_reset();
    send(2, GETM, 32'h3000);
    expect_grant(2, GETM, 32'h3000);
    tick();
    clear_reqs();
    tick();
    send(2, GETS, 32'h3040);
    tick();
    clear_reqs();
    tick();
    tick();
    check("hold_no_grant", 64'(bus_req.valid), 64'h0);
    check("hold_ready",    64'(req_ready[2]),  64'h0);
    respond(2, 1'b1);
    tick();
    respond(10, 1'b0);
    tick();
    resp_in = '0;
    tick();
    check("mem_resp_no_release", 64'(bus_req.valid), 64'h0);
    respond(2, 1'b0);
    expect_grant(2, GETS, 32'h3040);
    tick();
    resp_in = '0;
    check("retire_latency", 64'(bus_req.valid), 64'h0);
    tick();
    check("retire_grant",   64'(bus_req.valid), 64'h1);
    tick();
    check_perf("perf_gets_1", perf_gets, 32'd1);
    check_perf("perf_getm_1", perf_getm, 32'd1);

    // Stall with 3 full slots, pointer parked after 5
    do_reset();
    send(5, PUTM, 32'h4000);
    expect_grant(5, PUTM, 32'h4000);
    tick();
    clear_reqs();
    tick();
    bus_stall = 1'b1;
    send(1, PUTM, 32'h4100);
    send(4, PUTM, 32'h4400);
    send(6, PUTM, 32'h4600);
    tick();
    clear_reqs();
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_no_grant", 64'(bus_req.valid), 64'h0);
    end
    bus_stall = 1'b0;
    expect_grant(6, PUTM, 32'h4600);
    expect_grant(1, PUTM, 32'h4100);
    expect_grant(4, PUTM, 32'h4400);
    tick();
    tick();
    tick();
    tick();
    check_perf("perf_stall_5", perf_stall, 32'd5);
    check_perf("perf_putm_4",  perf_putm,  32'd4);

    // IDLE request is swallowed
    do_reset();
    send(5, IDLE, 32'h5000);
    tick();
    clear_reqs();
    check("idle_ready", 64'(req_ready[5]), 64'h1);
    tick();
    check("idle_no_grant", 64'(bus_req.valid), 64'h0);
    tick();

    // Reset with 4 full slots and 2 pending
    do_reset();
    send(2, GETS, 32'h6200);
    send(3, GETM, 32'h6300);
    expect_grant(2, GETS, 32'h6200);
    expect_grant(3, GETM, 32'h6300);
    tick();
    clear_reqs();
    tick();
    tick();
    bus_stall = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i != 2 && i != 3 && i < 6) send(i, PUTM, 32'h6000 + 32'(i));
    end
    tick();
    clear_reqs();
    check("pre_rst_ready", 64'(req_ready), 64'hCC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_stall = 1'b0;
    check("mid_rst_bus_req",  64'(bus_req),   64'h0);
    check("mid_rst_grant_id", 64'(grant_id),  64'h0);
    check("mid_rst_ready",    64'(req_ready), 64'hFF);
    check("mid_rst_perf",     64'(perf_putm), 64'h0);
    repeat (5) tick();
    check("no_stale_grant", 64'(bus_req.valid), 64'h0);
    send(2, GETS, 32'h6A00);
    expect_grant(2, GETS, 32'h6A00);
    tick();
    clear_reqs();
    tick();
    check("pending_cleared", 64'(bus_req.valid), 64'h1);
    tick();

    check("scoreboard_drain", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
